// File: rtl/lite16_pkg.sv
// LITE-16 shared definitions: fetch FSM state encoding,
// default address/data widths and the reset program counter.
package lite16_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;
   localparam logic [15:0] RESET_PC_DEF = 16'h0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: async active-low reset, load, increment.
// Ports: clk, rst, load/target (redirect), inc, pc (current), nxt (next).
module pc_counter
   import lite16_pkg::*;
#(
   parameter int W = ADDR_W_DEF,
   parameter logic [W-1:0] INIT = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         inc,
   input  logic [W-1:0] target,
   output logic [W-1:0] pc,
   output logic [W-1:0] nxt
);

   // Load has priority; increment wraps modulo 2^W.
   always_comb begin
      nxt = pc;
      if (load)
         nxt = target;
      else if (inc)
         nxt = pc + W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pc <= INIT;
      else
         pc <= nxt;
   end

endmodule

// File: rtl/fetch_unit.sv
// LITE-16 fetch stage: owns pc, issues memory reads, loads the IR.
// Ports: clk/rst, mem_* read handshake, stall/branch/ack, ir_*, pc.
module fetch_unit
   import lite16_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              instr_ack,
   output logic              ir_en,
   output logic [DATA_W-1:0] ir_data,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc
);

   state_t            state, state_n;
   logic              flush, flush_n;
   logic              req_n, en_n, valid_n;
   logic [DATA_W-1:0] data_n;
   logic [ADDR_W-1:0] addr_n, pc_nxt;
   logic              pc_load, pc_inc;

   pc_counter #(
      .W    (ADDR_W),
      .INIT (RESET_PC)
   ) u_pc (
      .clk    (clk),
      .rst    (rst),
      .load   (pc_load),
      .inc    (pc_inc),
      .target (branch_target),
      .pc     (pc),
      .nxt    (pc_nxt)
   );

   always_comb begin
      state_n = state;
      flush_n = flush;
      req_n   = mem_req;
      en_n    = 1'b0;
      data_n  = ir_data;
      valid_n = instr_valid;
      pc_load = 1'b0;
      pc_inc  = 1'b0;
      case (state)
         FETCH: begin
            if (branch_taken) begin
               pc_load = 1'b1;
            end else if (!stall) begin
               state_n = WAIT;
               req_n   = 1'b1;
            end
         end
         WAIT: begin
            if (mem_ready) begin
               req_n = 1'b0;
               if (branch_taken) begin
                  pc_load = 1'b1;
                  flush_n = 1'b0;
                  state_n = FETCH;
               end else if (flush) begin
                  flush_n = 1'b0;
                  state_n = FETCH;
               end else begin
                  data_n  = mem_rdata;
                  en_n    = 1'b1;
                  valid_n = 1'b1;
                  pc_inc  = 1'b1;
                  state_n = HOLD;
               end
            end else if (branch_taken) begin
               // Request stays outstanding; its data is dropped later.
               pc_load = 1'b1;
               flush_n = 1'b1;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               pc_load = 1'b1;
               valid_n = 1'b0;
               state_n = FETCH;
            end else if (instr_ack) begin
               valid_n = 1'b0;
               state_n = FETCH;
            end
         end
         default: begin
            state_n = FETCH;
            req_n   = 1'b0;
            valid_n = 1'b0;
            flush_n = 1'b0;
         end
      endcase
   end

   // Address follows pc but is frozen while a request is in flight,
   // so a branch during WAIT never disturbs the pending read.
   always_comb begin
      addr_n = pc_nxt;
      if (state == WAIT && state_n == WAIT)
         addr_n = mem_addr;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= FETCH;
         flush       <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= RESET_PC;
         ir_en       <= 1'b0;
         ir_data     <= '0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_n;
         flush       <= flush_n;
         mem_req     <= req_n;
         mem_addr    <= addr_n;
         ir_en       <= en_n;
         ir_data     <= data_n;
         instr_valid <= valid_n;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Observes {mem_req, ir_en, instr_valid, pc, mem_addr, ir_data}.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        instr_ack;
   logic        ir_en;
   logic [15:0] ir_data;
   logic        instr_valid;
   logic [15:0] pc;

   int checks;
   int errors;

   logic [50:0] obs;
   logic [50:0] exp;

   assign obs = {mem_req, ir_en, instr_valid, pc, mem_addr, ir_data};

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata),
      .mem_ready     (mem_ready),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr_ack     (instr_ack),
      .ir_en         (ir_en),
      .ir_data       (ir_data),
      .instr_valid   (instr_valid),
      .pc            (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      mem_rdata = '0;
      mem_ready = 1'b0;
      stall = 1'b0;
      branch_taken = 1'b0;
      branch_target = '0;
      instr_ack = 1'b0;
      step();
      step();
      exp = {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL reset: got %h exp %h", obs, exp);
      end
      rst = 1'b1;
   endtask

   task automatic test_sequential();
      logic [15:0] words [3];
      words[0] = 16'hAABB;
      words[1] = 16'h1234;
      words[2] = 16'h5678;
      mem_ready = 1'b1;
      instr_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         exp = {1'b1, 1'b0, 1'b0, 16'(i), 16'(i),
                (i == 0) ? 16'h0000 : words[i-1]};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL seq_issue%0d: got %h exp %h", i, obs, exp);
         end
         mem_rdata = words[i];
         if (i == 2) instr_ack = 1'b0;
         step();
         exp = {1'b0, 1'b1, 1'b1, 16'(i+1), 16'(i+1), words[i]};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL seq_load%0d: got %h exp %h", i, obs, exp);
         end
         if (i < 2) begin
            step();
            exp = {1'b0, 1'b0, 1'b0, 16'(i+1), 16'(i+1), words[i]};
            checks++;
            if (obs !== exp) begin
               errors++;
               $display("FAIL seq_ack%0d: got %h exp %h", i, obs, exp);
            end
         end
      end
      step();
      exp = {1'b0, 1'b0, 1'b1, 16'h0003, 16'h0003, 16'h5678};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL seq_hold: got %h exp %h", obs, exp);
      end
      instr_ack = 1'b1;
      step();
      exp = {1'b0, 1'b0, 1'b0, 16'h0003, 16'h0003, 16'h5678};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL seq_release: got %h exp %h", obs, exp);
      end
      instr_ack = 1'b0;
   endtask

   task automatic test_wait_states();
      mem_ready = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         exp = {1'b1, 1'b0, 1'b0, 16'h0003, 16'h0003, 16'h5678};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL wait%0d: got %h exp %h", i, obs, exp);
         end
         if (i < 3) step();
      end
      mem_ready = 1'b1;
      mem_rdata = 16'hBEEF;
      stall = 1'b1;
      step();
      exp = {1'b0, 1'b1, 1'b1, 16'h0004, 16'h0004, 16'hBEEF};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL wait_load: got %h exp %h", obs, exp);
      end
      mem_ready = 1'b0;
      step();
      exp = {1'b0, 1'b0, 1'b1, 16'h0004, 16'h0004, 16'hBEEF};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL wait_hold: got %h exp %h", obs, exp);
      end
      stall = 1'b0;
      instr_ack = 1'b1;
      step();
      exp = {1'b0, 1'b0, 1'b0, 16'h0004, 16'h0004, 16'hBEEF};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL wait_ack: got %h exp %h", obs, exp);
      end
      instr_ack = 1'b0;
   endtask

   task automatic test_branch_wait();
      step();
      branch_taken = 1'b1;
      branch_target = 16'h0040;
      step();
      exp = {1'b1, 1'b0, 1'b0, 16'h0040, 16'h0004, 16'hBEEF};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL bw_redirect: got %h exp %h", obs, exp);
      end
      branch_taken = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 16'hDEAD;
      step();
      exp = {1'b0, 1'b0, 1'b0, 16'h0040, 16'h0040, 16'hBEEF};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL bw_discard: got %h exp %h", obs, exp);
      end
      mem_ready = 1'b0;
      step();
      exp = {1'b1, 1'b0, 1'b0, 16'h0040, 16'h0040, 16'hBEEF};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL bw_refetch: got %h exp %h", obs, exp);
      end
      mem_ready = 1'b1;
      mem_rdata = 16'h1111;
      step();
      exp = {1'b0, 1'b1, 1'b1, 16'h0041, 16'h0041, 16'h1111};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL bw_load: got %h exp %h", obs, exp);
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_branch_ack();
      branch_taken = 1'b1;
      branch_target = 16'h0080;
      instr_ack = 1'b1;
      step();
      exp = {1'b0, 1'b0, 1'b0, 16'h0080, 16'h0080, 16'h1111};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL ba_hold: got %h exp %h", obs, exp);
      end
      branch_taken = 1'b0;
      instr_ack = 1'b0;
      step();
      exp = {1'b1, 1'b0, 1'b0, 16'h0080, 16'h0080, 16'h1111};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL ba_issue: got %h exp %h", obs, exp);
      end
      mem_ready = 1'b1;
      mem_rdata = 16'h2222;
      branch_taken = 1'b1;
      branch_target = 16'h00C0;
      step();
      exp = {1'b0, 1'b0, 1'b0, 16'h00C0, 16'h00C0, 16'h1111};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL ba_same_edge: got %h exp %h", obs, exp);
      end
      branch_taken = 1'b0;
      mem_ready = 1'b0;
   endtask

   task automatic test_wrap_stall();
      branch_taken = 1'b1;
      branch_target = 16'hFFFF;
      step();
      branch_taken = 1'b0;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         exp = {1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h1111};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL stall%0d: got %h exp %h", i, obs, exp);
         end
      end
      stall = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 16'hCAFE;
      step();
      exp = {1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h1111};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL wrap_issue: got %h exp %h", obs, exp);
      end
      step();
      exp = {1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'hCAFE};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL wrap_pc: got %h exp %h", obs, exp);
      end
      mem_ready = 1'b0;
      instr_ack = 1'b1;
      step();
      instr_ack = 1'b0;
   endtask

   task automatic test_async_reset();
      branch_taken = 1'b1;
      branch_target = 16'h0010;
      step();
      branch_taken = 1'b0;
      step();
      exp = {1'b1, 1'b0, 1'b0, 16'h0010, 16'h0010, 16'hCAFE};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL ar_wait: got %h exp %h", obs, exp);
      end
      #2;
      rst = 1'b0;
      #1;
      exp = {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL ar_async: got %h exp %h", obs, exp);
      end
      step();
      rst = 1'b1;
      step();
      exp = {1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL ar_restart: got %h exp %h", obs, exp);
      end
      mem_ready = 1'b1;
      mem_rdata = 16'h4321;
      step();
      exp = {1'b0, 1'b1, 1'b1, 16'h0001, 16'h0001, 16'h4321};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL ar_load: got %h exp %h", obs, exp);
      end
      mem_ready = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_sequential();
      test_wait_states();
      test_branch_wait();
      test_branch_ack();
      test_wrap_stall();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
